// File: rtl/zb_tx_pkg.sv
// Shared types and timing constants for the 802.15.4 O-QPSK transmit path.
package zb_tx_pkg;

  // Cycles between consecutive chip issues. This is half of one shaper pulse.
  localparam int SAMPLES_PER_CHIP = 5;

  // Length of one half-sine pulse, in samples.
  localparam int PULSE_LEN = 2 * SAMPLES_PER_CHIP;

  // Cycles from the last issue until both shapers have emptied.
  localparam int DRAIN_CYCLES = PULSE_LEN + 1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARM   = 3'd1,
    ST_RUN   = 3'd2,
    ST_PAD   = 3'd3,
    ST_DRAIN = 3'd4
  } sched_state_t;

  typedef enum logic {
    LANE_I = 1'b0,
    LANE_Q = 1'b1
  } lane_t;

  function automatic lane_t other_lane(input lane_t l);
    return (l == LANE_I) ? LANE_Q : LANE_I;
  endfunction

endpackage

// File: rtl/oqpsk_chip_scheduler.sv
// O-QPSK chip scheduler: splits the chip stream alternately onto the I and Q
// half-sine shapers, one chip every SAMPLES_PER_CHIP cycles, and frames each
// transmission (start, odd-length pad, underrun abort, drain, done).
//
// state    | meaning
// ---------+-----------------------------------------------------------------
// ST_IDLE  | no frame; waits for i_tx_start, holds phase/lane cleared
// ST_ARM   | ready held high until the first chip is accepted
// ST_RUN   | one chip accepted at each phase 0, lanes alternate I/Q
// ST_PAD   | odd-length frame: a zero chip goes to Q at the next phase 0
// ST_DRAIN | waits DRAIN_CYCLES after the last issue, then pulses done
module oqpsk_chip_scheduler #(
  parameter int SAMPLES_PER_CHIP = zb_tx_pkg::SAMPLES_PER_CHIP,
  parameter int CNT_W            = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_tx_start,
  input  logic             i_chip,
  input  logic             i_chip_valid,
  input  logic             i_chip_last,
  output logic             o_chip_ready,
  output logic             o_i_bit,
  output logic             o_q_bit,
  output logic             o_i_valid,
  output logic             o_q_valid,
  input  logic             i_i_read,
  input  logic             i_q_read,
  output logic             o_busy,
  output logic             o_tx_done,
  output logic             o_underrun,
  output logic             o_sync_err,
  output logic [CNT_W-1:0] o_chip_count
);
  import zb_tx_pkg::*;

  localparam int PH_W = (SAMPLES_PER_CHIP > 1) ? $clog2(SAMPLES_PER_CHIP) : 1;
  localparam int DR_W = $clog2(DRAIN_CYCLES + 1);

  localparam logic [PH_W-1:0] PH_LAST = PH_W'(SAMPLES_PER_CHIP - 1);
  localparam logic [PH_W-1:0] PH_ONE  = PH_W'(1);
  localparam logic [DR_W-1:0] DR_LOAD = DR_W'(DRAIN_CYCLES);

  sched_state_t     state_q, state_d;
  lane_t            lane_q, lane_d;
  logic [PH_W-1:0]  phase_q, phase_d;
  logic [PH_W-1:0]  phase_inc;
  logic [DR_W-1:0]  drain_q, drain_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             i_bit_q, i_bit_d;
  logic             q_bit_q, q_bit_d;
  logic             i_valid_q, i_valid_d;
  logic             q_valid_q, q_valid_d;
  logic             underrun_q, underrun_d;
  logic             sync_err_q, sync_err_d;
  logic             chip_ready;
  logic             tx_done;
  logic             xfer;

  // Phase wraps 0..SAMPLES_PER_CHIP-1; phase 0 is the chip issue slot.
  assign phase_inc = (phase_q == PH_LAST) ? '0 : phase_q + 1'b1;

  // State and datapath registers. Reset aborts a frame with no done pulse.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= ST_IDLE;
      lane_q     <= LANE_I;
      phase_q    <= '0;
      drain_q    <= '0;
      count_q    <= '0;
      i_bit_q    <= 1'b0;
      q_bit_q    <= 1'b0;
      i_valid_q  <= 1'b0;
      q_valid_q  <= 1'b0;
      underrun_q <= 1'b0;
      sync_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      lane_q     <= lane_d;
      phase_q    <= phase_d;
      drain_q    <= drain_d;
      count_q    <= count_d;
      i_bit_q    <= i_bit_d;
      q_bit_q    <= q_bit_d;
      i_valid_q  <= i_valid_d;
      q_valid_q  <= q_valid_d;
      underrun_q <= underrun_d;
      sync_err_q <= sync_err_d;
    end
  end

  // Next-state logic, handshake, and issue scheduling.
  always_comb begin
    state_d    = state_q;
    lane_d     = lane_q;
    phase_d    = phase_q;
    count_d    = count_q;
    i_bit_d    = i_bit_q;
    q_bit_d    = q_bit_q;
    i_valid_d  = 1'b0;
    q_valid_d  = 1'b0;
    underrun_d = underrun_q;
    // A strobe that lands while the shaper is still mid-pulse is a sync error.
    sync_err_d = sync_err_q | (i_valid_q & ~i_i_read) | (q_valid_q & ~i_q_read);
    // The drain counter runs freely between issues; each issue reloads it, so
    // on entry to DRAIN it already holds the cycles left since the last issue.
    drain_d    = (drain_q != '0) ? drain_q - 1'b1 : drain_q;
    chip_ready = 1'b0;
    tx_done    = 1'b0;
    xfer       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        phase_d = '0;
        lane_d  = LANE_I;
        if (i_tx_start) begin
          state_d    = ST_ARM;
          underrun_d = 1'b0;
          sync_err_d = 1'b0;
          count_d    = '0;
        end
      end

      ST_ARM: begin
        chip_ready = 1'b1;
        if (i_chip_valid) begin
          xfer    = 1'b1;
          phase_d = PH_ONE;
          state_d = i_chip_last ? ST_PAD : ST_RUN;
        end
      end

      ST_RUN: begin
        phase_d = phase_inc;
        if (phase_q == '0) begin
          chip_ready = 1'b1;
          if (i_chip_valid) begin
            xfer = 1'b1;
            if (i_chip_last) begin
              state_d = (lane_q == LANE_I) ? ST_PAD : ST_DRAIN;
            end
          end else begin
            // Missing chip at its slot: stop issuing, leave I unpadded.
            underrun_d = 1'b1;
            state_d    = ST_DRAIN;
          end
        end
      end

      ST_PAD: begin
        phase_d = phase_inc;
        if (phase_q == '0) begin
          q_bit_d   = 1'b0;
          q_valid_d = 1'b1;
          drain_d   = DR_LOAD;
          state_d   = ST_DRAIN;
        end
      end

      ST_DRAIN: begin
        if (drain_q == '0) begin
          tx_done = 1'b1;
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (xfer) begin
      lane_d  = other_lane(lane_q);
      drain_d = DR_LOAD;
      if (count_q != '1) begin
        count_d = count_q + 1'b1;
      end
      if (lane_q == LANE_I) begin
        i_bit_d   = i_chip;
        i_valid_d = 1'b1;
      end else begin
        q_bit_d   = i_chip;
        q_valid_d = 1'b1;
      end
    end
  end

  assign o_chip_ready = chip_ready;
  assign o_tx_done    = tx_done;
  assign o_busy       = (state_q != ST_IDLE);
  assign o_i_bit      = i_bit_q;
  assign o_q_bit      = q_bit_q;
  assign o_i_valid    = i_valid_q;
  assign o_q_valid    = q_valid_q;
  assign o_underrun   = underrun_q;
  assign o_sync_err   = sync_err_q;
  assign o_chip_count = count_q;

endmodule

// File: tb/tb_oqpsk_chip_scheduler.sv
// Self-checking bench for oqpsk_chip_scheduler: table of directed frames,
// an async-reset sequence, and randomized frames against a timing model.
module tb_oqpsk_chip_scheduler;
  localparam int CNT_W = 16;

  logic             i_clk;
  logic             i_rst_n;
  logic             i_tx_start;
  logic             i_chip;
  logic             i_chip_valid;
  logic             i_chip_last;
  logic             o_chip_ready;
  logic             o_i_bit;
  logic             o_q_bit;
  logic             o_i_valid;
  logic             o_q_valid;
  logic             i_i_read;
  logic             i_q_read;
  logic             o_busy;
  logic             o_tx_done;
  logic             o_underrun;
  logic             o_sync_err;
  logic [CNT_W-1:0] o_chip_count;

  oqpsk_chip_scheduler #(.SAMPLES_PER_CHIP(5), .CNT_W(CNT_W)) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_tx_start   (i_tx_start),
    .i_chip       (i_chip),
    .i_chip_valid (i_chip_valid),
    .i_chip_last  (i_chip_last),
    .o_chip_ready (o_chip_ready),
    .o_i_bit      (o_i_bit),
    .o_q_bit      (o_q_bit),
    .o_i_valid    (o_i_valid),
    .o_q_valid    (o_q_valid),
    .i_i_read     (i_i_read),
    .i_q_read     (i_q_read),
    .o_busy       (o_busy),
    .o_tx_done    (o_tx_done),
    .o_underrun   (o_underrun),
    .o_sync_err   (o_sync_err),
    .o_chip_count (o_chip_count)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  // Expected issue events, in cycles counted from the start request (cycle 0);
  // the first transfer T is cycle 1.
  int exp_i_t[$], exp_i_b[$], exp_q_t[$], exp_q_b[$];
  int got_i_t[$], got_i_b[$], got_q_t[$], got_q_b[$], got_done[$];
  int m_done, m_count, m_under, m_sync;

  // Frame model: chip k transfers at T+5k and is issued at T+5k+1 on lane k%2.
  // Odd complete frames add a zero Q chip one slot later. Done lands 11 cycles
  // after the final issue. A missing chip at slot d leaves d chips issued.
  task automatic model(input int n, input logic [63:0] chips, input int drop,
                       input int ilow, input int qlow);
    int  issued;
    int  last;
    bit  pad;
    exp_i_t.delete(); exp_i_b.delete(); exp_q_t.delete(); exp_q_b.delete();
    issued = (drop >= 0) ? drop : n;
    pad    = (drop < 0) && ((n % 2) == 1);
    for (int k = 0; k < issued; k++) begin
      if ((k % 2) == 0) begin
        exp_i_t.push_back(5 * k + 2);
        exp_i_b.push_back(int'(chips[k]));
      end else begin
        exp_q_t.push_back(5 * k + 2);
        exp_q_b.push_back(int'(chips[k]));
      end
    end
    if (pad) begin
      exp_q_t.push_back(5 * n + 2);
      exp_q_b.push_back(0);
    end
    last    = pad ? (5 * n + 2) : (5 * (issued - 1) + 2);
    m_done  = last + 11;
    m_count = issued;
    m_under = (drop >= 0) ? (5 * drop + 2) : -1;
    m_sync  = -1;
    foreach (exp_i_t[j])
      if (exp_i_t[j] == ilow + 1 && (m_sync < 0 || exp_i_t[j] + 1 < m_sync)) m_sync = exp_i_t[j] + 1;
    foreach (exp_q_t[j])
      if (exp_q_t[j] == qlow + 1 && (m_sync < 0 || exp_q_t[j] + 1 < m_sync)) m_sync = exp_q_t[j] + 1;
  endtask

  // Spreader/shaper side: chip k presented from just after chip k-1 is taken
  // until its own slot, all by the clock, with no DUT feedback.
  task automatic drive_cycle(input int c, input int n, input logic [63:0] chips, input int drop,
                             input int ilow, input int qlow, input int start_off);
    int idx;
    idx          = (c + 3) / 5;
    i_tx_start   = (c == 0) || ((start_off > 0) && (c == 1 + start_off));
    i_chip_valid = (idx < n) && ((drop < 0) || (idx < drop));
    i_chip       = (idx < n) ? chips[idx] : 1'b0;
    i_chip_last  = (idx == n - 1);
    i_i_read     = (c != 1 + ilow);
    i_q_read     = (c != 1 + qlow);
  endtask

  task automatic quiet_inputs();
    i_tx_start   = 1'b0;
    i_chip       = 1'b0;
    i_chip_valid = 1'b0;
    i_chip_last  = 1'b0;
    i_i_read     = 1'b1;
    i_q_read     = 1'b1;
  endtask

  // exp_done is relative to the first transfer T.
  task automatic run_frame(input string tag, input int n, input logic [63:0] chips, input int drop,
                           input int ilow, input int qlow, input int start_off,
                           input int exp_count, input int exp_done, input bit exp_under, input bit exp_sync);
    int ut, st, stop, nmin;
    got_i_t.delete(); got_i_b.delete(); got_q_t.delete(); got_q_b.delete(); got_done.delete();
    ut = -1;
    st = -1;
    model(n, chips, drop, ilow, qlow);
    stop = exp_done + 1 + 3;
    @(negedge i_clk);
    drive_cycle(0, n, chips, drop, ilow, qlow, start_off);
    for (int c = 1; c <= stop; c++) begin
      @(negedge i_clk);
      if (o_i_valid) begin got_i_t.push_back(c); got_i_b.push_back(int'(o_i_bit)); end
      if (o_q_valid) begin got_q_t.push_back(c); got_q_b.push_back(int'(o_q_bit)); end
      if (o_tx_done) got_done.push_back(c);
      if (o_underrun && ut < 0) ut = c;
      if (o_sync_err && st < 0) st = c;
      if (c == 1) begin
        check({tag, " busy in ARM"}, o_busy, 1);
        check({tag, " ready in ARM"}, o_chip_ready, 1);
      end
      drive_cycle(c, n, chips, drop, ilow, qlow, start_off);
    end
    check({tag, " done pulses"}, got_done.size(), 1);
    check({tag, " done cycle"}, (got_done.size() > 0) ? got_done[0] : -1, exp_done + 1);
    check({tag, " I issue count"}, got_i_t.size(), exp_i_t.size());
    check({tag, " Q issue count"}, got_q_t.size(), exp_q_t.size());
    nmin = (got_i_t.size() < exp_i_t.size()) ? got_i_t.size() : exp_i_t.size();
    for (int j = 0; j < nmin; j++) begin
      check($sformatf("%s I[%0d] cycle", tag, j), got_i_t[j], exp_i_t[j]);
      check($sformatf("%s I[%0d] bit", tag, j), got_i_b[j], exp_i_b[j]);
    end
    nmin = (got_q_t.size() < exp_q_t.size()) ? got_q_t.size() : exp_q_t.size();
    for (int j = 0; j < nmin; j++) begin
      check($sformatf("%s Q[%0d] cycle", tag, j), got_q_t[j], exp_q_t[j]);
      check($sformatf("%s Q[%0d] bit", tag, j), got_q_b[j], exp_q_b[j]);
    end
    check({tag, " chip count"}, o_chip_count, exp_count);
    check({tag, " underrun sticky"}, o_underrun, exp_under);
    check({tag, " underrun rise"}, ut, m_under);
    check({tag, " sync_err sticky"}, o_sync_err, exp_sync);
    check({tag, " sync_err rise"}, st, m_sync);
    check({tag, " idle after done"}, o_busy, 0);
    if (exp_i_b.size() > 0) check({tag, " I bit held"}, o_i_bit, exp_i_b[exp_i_b.size() - 1]);
    if (exp_q_b.size() > 0) check({tag, " Q bit held"}, o_q_bit, exp_q_b[exp_q_b.size() - 1]);
    quiet_inputs();
    for (int k = 0; k < 300 && o_busy; k++) @(negedge i_clk);
    if (o_busy) begin
      i_rst_n = 1'b0;
      @(negedge i_clk);
      i_rst_n = 1'b1;
    end
  endtask

  typedef struct {
    string       name;
    int          n;
    logic [63:0] chips;
    int          drop;
    int          ilow;
    int          qlow;
    int          start_off;
    int          exp_count;
    int          exp_done;
    bit          exp_under;
    bit          exp_sync;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, drop, ilow, qlow, start_off, ndone, pre_cnt;
    logic [63:0] chips;

    vecs[0] = '{"frame32",   32, 64'h0000_0000_C3A5_96F0, -1, -1, -1,  0, 32, 167, 1'b0, 1'b0};
    vecs[1] = '{"frame3",     3, 64'h5,                   -1, -1, -1,  0,  3,  27, 1'b0, 1'b0};
    vecs[2] = '{"underrun",   8, 64'hB6,                   4, -1, -1,  0,  4,  27, 1'b1, 1'b0};
    vecs[3] = '{"sync_q",     4, 64'h9,                   -1, -1,  6,  0,  4,  27, 1'b0, 1'b1};
    vecs[4] = '{"mid_start",  6, 64'h2D,                  -1, -1, -1, 13,  6,  37, 1'b0, 1'b0};
    vecs[5] = '{"frame1",     1, 64'h1,                   -1, -1, -1,  0,  1,  17, 1'b0, 1'b0};

    quiet_inputs();
    i_rst_n = 1'b0;
    repeat (3) @(negedge i_clk);
    check("reset flags", {o_busy, o_chip_ready, o_i_valid, o_q_valid, o_i_bit, o_q_bit,
                          o_tx_done, o_underrun, o_sync_err}, 0);
    check("reset count", o_chip_count, 0);
    i_rst_n = 1'b1;
    repeat (2) @(negedge i_clk);
    check("idle after reset", {o_busy, o_chip_ready, o_tx_done}, 0);

    for (int v = 0; v < 6; v++) begin
      run_frame(vecs[v].name, vecs[v].n, vecs[v].chips, vecs[v].drop, vecs[v].ilow, vecs[v].qlow,
                vecs[v].start_off, vecs[v].exp_count, vecs[v].exp_done, vecs[v].exp_under, vecs[v].exp_sync);
      repeat (2) @(negedge i_clk);
    end

    // Asynchronous reset in the middle of RUN, with a sync error already set.
    chips = 64'hF0F0_1234;
    @(negedge i_clk);
    drive_cycle(0, 20, chips, -1, -1, 6, 0);
    for (int c = 1; c <= 31; c++) begin
      @(negedge i_clk);
      if (c < 31) drive_cycle(c, 20, chips, -1, -1, 6, 0);
    end
    pre_cnt = o_chip_count;
    check("pre-reset count", pre_cnt, 6);
    check("pre-reset sync_err", o_sync_err, 1);
    #2 i_rst_n = 1'b0;
    #1;
    check("async reset flags", {o_busy, o_chip_ready, o_i_valid, o_q_valid, o_i_bit, o_q_bit,
                                o_tx_done, o_underrun, o_sync_err}, 0);
    check("async reset count", o_chip_count, 0);
    quiet_inputs();
    repeat (3) @(negedge i_clk);
    i_rst_n = 1'b1;
    ndone = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge i_clk);
      if (o_tx_done) ndone++;
    end
    check("no done after reset", ndone, 0);
    check("idle after reset abort", o_busy, 0);
    run_frame("post_reset", 5, 64'h13, -1, -1, -1, 0, 5, 37, 1'b0, 1'b0);

    for (int r = 0; r < 12; r++) begin
      n         = $urandom_range(1, 40);
      chips     = {$urandom(), $urandom()};
      drop      = (n >= 2 && $urandom_range(0, 3) == 0) ? $urandom_range(1, n - 1) : -1;
      ilow      = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 5 * n) : -1;
      qlow      = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 5 * n) : -1;
      start_off = ($urandom_range(0, 3) == 0) ? $urandom_range(2, 5 * n) : 0;
      model(n, chips, drop, ilow, qlow);
      run_frame($sformatf("rand%0d", r), n, chips, drop, ilow, qlow, start_off,
                m_count, m_done - 1, m_under >= 0, m_sync >= 0);
      repeat ($urandom_range(1, 4)) @(negedge i_clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/oqpsk_chip_scheduler.md
# oqpsk_chip_scheduler

Sequences the 802.15.4 O-QPSK chip stream into the two half-sine pulse shapers (I and Q) of the 2.4 GHz transmitter. Sits between the chip spreader and the shapers. It splits chips alternately onto the I and Q lanes, one chip every SAMPLES_PER_CHIP cycles, which gives Q its half-pulse offset. It also frames each transmission: start, odd-length padding, underrun abort, drain, and a done indication.

## Interface
- SAMPLES_PER_CHIP, 5: cycles between consecutive chip issues (half of one 10-sample shaper pulse).
- CNT_W, 16: width of chip counter.
- i_clk  in  1  sample clock.
- i_rst_n  in  1  reset; asynchronous, active-low.
- i_tx_start  in  1  one-cycle frame start request.
- i_chip  in  1  chip value from spreader.
- i_chip_valid  in  1  chip present.
- i_chip_last  in  1  qualifies the final chip of the frame.
- o_chip_ready  out  1  chip accepted when high with i_chip_valid.
- o_i_bit, o_q_bit  out  1 each  chip to I / Q shaper stream input.
- o_i_valid, o_q_valid  out  1 each  one-cycle issue strobe to I / Q shaper valid input.
- i_i_read, i_q_read  in  1 each  shaper idle/read flags (counter at 0).
- o_busy  out  1  state ≠ IDLE.
- o_tx_done  out  1  one-cycle end-of-frame pulse.
- o_underrun  out  1  sticky, chip missing at issue slot.
- o_sync_err  out  1  sticky, shaper not at read point on issue.
- o_chip_count  out  CNT_W  chips issued this frame, pad chip excluded.

## Operation
- States: IDLE, ARM, RUN, PAD, DRAIN.
- IDLE:
  - i_tx_start → ARM.
  - Clears o_underrun, o_sync_err, o_chip_count, phase, and lane (lane = I).
- ARM:
  - o_chip_ready = 1 continuously.
  - The first transfer → RUN with phase = 1.
- RUN:
  - Phase counter counts 0..SAMPLES_PER_CHIP-1 and wraps.
  - o_chip_ready = 1 only at phase 0 (combinational).
  - Transfer (ready & valid) latches i_chip onto the current lane, increments o_chip_count, and toggles the lane.
- Issue:
  - The cycle after a transfer, the lane's valid is high for exactly one cycle.
  - The lane's bit is held until that lane's next issue.
- Last chip:
  - If i_chip_last is on an I transfer → PAD.
  - If on a Q transfer → DRAIN.
- PAD:
  - At the next phase 0, issues Q bit = 0 with no ready and no count increment, then → DRAIN.
- Underrun:
  - RUN at phase 0 with !i_chip_valid sets o_underrun and → DRAIN.
  - No further issues.
  - The I lane is not padded.
- DRAIN:
  - Counts 11 cycles from the last issue so both shapers finish their pulses.
  - o_tx_done pulses in the cycle last-issue + 11, then → IDLE.
- i_tx_start outside IDLE is ignored.
- Sync check: on any o_x_valid cycle, if the matching i_x_read = 0, set o_sync_err. Operation continues.
- o_chip_count saturates at all-ones.

## Timing
- Reset values: all outputs 0, state IDLE, lane I.
- Reset mid-frame aborts immediately with no o_tx_done.
- Latency: first transfer at T gives I issue at T+1, Q issue at T+6, and lane issues every 10 cycles thereafter.
- Issue strobes land exactly when each shaper counter returns to 0, so pulses are back-to-back with no gap.
- i_chip and i_chip_last must be stable while i_chip_valid is high until transfer.

## Structure
- Package zb_tx_pkg holds:
  - the sched_state_t enum;
  - the SAMPLES_PER_CHIP and PULSE_LEN = 10 constants;
  - the DRAIN_CYCLES = PULSE_LEN + 1 constant.
- Single module with no sub-module.
- The phase counter, lane toggle, and drain counter live inline.
- The top-level transmitter instantiates this block plus two pulse shapers.

## Test plan
- 32-chip frame, valid always high, first transfer at T:
  - I strobes at T+1+10k and Q strobes at T+6+10k, k = 0..15.
  - o_tx_done at T+167, o_chip_count = 32, flags 0.
- 3-chip frame 1,0,1:
  - I = 1 at T+1, Q = 0 at T+6, I = 1 at T+11, pad Q = 0 at T+16.
  - o_chip_count = 3, o_tx_done at T+27.
- Valid dropped at the 5th slot (T+20):
  - o_underrun = 1 at T+21.
  - No strobe after T+16, o_tx_done at T+27.
- Hold i_q_read = 0 at the Q issue of T+6:
  - o_sync_err = 1 from T+7 and stays sticky until the next i_tx_start.
- i_tx_start pulsed mid-frame: ignored, with strobe timing unchanged.
- Async reset asserted mid-RUN:
  - All outputs are 0 immediately.
  - No o_tx_done.
  - After release, a new i_tx_start works normally.
